lsu_port_arbiter: RTL and testbench

- Shares the single LSU data port between two requesters: m0 (pipeline MEM stage) and m1 (debug/program loader).
- Registers the winning request, drives the LSU for exactly one cycle, captures load data, and returns a one-cycle response to the granted master.
- Rejects misaligned or illegal-funct3 accesses without touching the LSU.
- Sits between the core/loader and lsu; nothing else drives lsu_wren or lsu_addr.

---
 rtl/lsu_arb_pkg.sv | 34 +++
 rtl/lsu_port_arbiter_if.sv | 23 ++
 rtl/lsu_arb_grant.sv | 33 +++
 rtl/lsu_port_arbiter.sv | 99 +++++++++
 tb/tb_lsu_port_arbiter.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_arb_pkg.sv
// Shared constants and the access-legality check for the LSU port arbiter.
// FSM state encodings are plain localparams so legacy code can compare against them.
package lsu_arb_pkg;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StIssue = 2'd1;
    localparam logic [1:0] StResp  = 2'd2;

    localparam logic [2:0] F3Lb  = 3'b000;
    localparam logic [2:0] F3Lh  = 3'b001;
    localparam logic [2:0] F3Lw  = 3'b010;
    localparam logic [2:0] F3Lbu = 3'b100;
    localparam logic [2:0] F3Lhu = 3'b101;
    localparam logic [2:0] F3Sb  = 3'b000;
    localparam logic [2:0] F3Sh  = 3'b001;
    localparam logic [2:0] F3Sw  = 3'b010;

    // Unsigned loads have no store counterpart; halves and words must be naturally aligned.
    function automatic logic is_legal(input logic we, input logic [2:0] funct3,
                                      input logic [1:0] addr_lo);
        logic ok;
        ok = 1'b0;
        case (funct3)
            F3Lb:    ok = 1'b1;
            F3Lh:    ok = ~addr_lo[0];
            F3Lw:    ok = (addr_lo == 2'b00);
            F3Lbu:   ok = ~we;
            F3Lhu:   ok = ~we & ~addr_lo[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lsu_port_arbiter_if.sv
// Request/response channel between one LSU requester and the arbiter.
interface lsu_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        funct3;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              resp_valid;

    modport master (
        output req_valid, req_we, funct3, addr, wdata,
        input  req_ready, resp_valid
    );

    modport slave (
        input  req_valid, req_we, funct3, addr, wdata,
        output req_ready, resp_valid
    );
endinterface

// File: rtl/lsu_arb_grant.sv
// Two-way grant logic: fixed m0 > m1 priority, or round-robin when LSU_ARB_RR_EN is defined.
// The grant is one-hot (or zero) and only ever selects a master whose valid is high.
module lsu_arb_grant (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] valid_i,
    input  logic       accept_i,
    output logic [1:0] gnt_o
);
`ifdef LSU_ARB_RR_EN
    logic prio_q;  // 1: m1 wins the next contended cycle

    always_comb begin
        gnt_o = valid_i;
        if (valid_i == 2'b11) begin
            gnt_o = prio_q ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prio_q <= 1'b0;
        end else if (accept_i) begin
            prio_q <= gnt_o[0];
        end
    end
`else
    logic unused_rr;

    assign gnt_o     = valid_i[0] ? 2'b01 : {valid_i[1], 1'b0};
    assign unused_rr = ^{clk_i, rst_ni, accept_i};
`endif
endmodule

// File: rtl/lsu_port_arbiter.sv
// Shares the single LSU data port between m0 (MEM stage) and m1 (debug/loader).
// Optional round-robin arbitration via LSU_ARB_RR_EN (see lsu_arb_grant).
module lsu_port_arbiter
    import lsu_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    lsu_port_arbiter_if.slave   m0,
    lsu_port_arbiter_if.slave   m1,
    output logic [DATA_W-1:0]   resp_rdata_o,
    output logic                resp_err_o,
    output logic                lsu_wren_o,
    output logic [2:0]          lsu_funct3_o,
    output logic [ADDR_W-1:0]   lsu_addr_o,
    output logic [DATA_W-1:0]   lsu_st_data_o,
    input  logic [DATA_W-1:0]   lsu_ld_data_i
);
    logic [1:0]        state_q, state_d;
    logic              we_q;
    logic [2:0]        funct3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              gnt_q;  // 0: m0 owns the in-flight access, 1: m1
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;

    logic [1:0] req_valid;
    logic [1:0] gnt;
    logic       can_accept;
    logic       handshake;
    logic       legal;

    assign req_valid  = {m1.req_valid, m0.req_valid};
    assign can_accept = (state_q != StIssue);
    assign handshake  = can_accept & (|req_valid);

    lsu_arb_grant u_grant (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .valid_i  (req_valid),
        .accept_i (handshake),
        .gnt_o    (gnt)
    );

    assign m0.req_ready = can_accept & gnt[0];
    assign m1.req_ready = can_accept & gnt[1];

    assign legal = is_legal(we_q, funct3_q, addr_q[1:0]);

    always_comb begin
        state_d = StIdle;
        unique case (state_q)
            StIdle:  state_d = handshake ? StIssue : StIdle;
            StIssue: state_d = StResp;
            StResp:  state_d = handshake ? StIssue : StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            we_q     <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= '0;
            wdata_q  <= '0;
            gnt_q    <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (handshake) begin
                gnt_q    <= gnt[1];
                we_q     <= gnt[1] ? m1.req_we : m0.req_we;
                funct3_q <= gnt[1] ? m1.funct3 : m0.funct3;
                addr_q   <= gnt[1] ? m1.addr   : m0.addr;
                wdata_q  <= gnt[1] ? m1.wdata  : m0.wdata;
            end
            if (state_q == StIssue) begin
                rdata_q <= (legal && !we_q) ? lsu_ld_data_i : '0;
                err_q   <= ~legal;
            end
        end
    end

    // Async reset clears state_q immediately, so an in-flight write drops without a clock.
    assign lsu_wren_o    = (state_q == StIssue) & we_q & legal;
    assign lsu_funct3_o  = funct3_q;
    assign lsu_addr_o    = addr_q;
    assign lsu_st_data_o = wdata_q;

    assign m0.resp_valid = (state_q == StResp) & ~gnt_q;
    assign m1.resp_valid = (state_q == StResp) & gnt_q;
    assign resp_rdata_o  = rdata_q;
    assign resp_err_o    = err_q;
endmodule

// File: tb/tb_lsu_port_arbiter.sv
// Scoreboard bench for lsu_port_arbiter: drivers push expected responses at handshake,
// a monitor pops and compares on every resp_valid. Works with or without LSU_ARB_RR_EN.
module tb_lsu_port_arbiter;
    import lsu_arb_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lsu_port_arbiter_if m0_if ();
    lsu_port_arbiter_if m1_if ();

    logic [31:0] resp_rdata, lsu_addr, lsu_st_data, lsu_ld_data, ld_word, ld_shift;
    logic        resp_err, lsu_wren;
    logic [2:0]  lsu_funct3;

    lsu_port_arbiter dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .m0            (m0_if),
        .m1            (m1_if),
        .resp_rdata_o  (resp_rdata),
        .resp_err_o    (resp_err),
        .lsu_wren_o    (lsu_wren),
        .lsu_funct3_o  (lsu_funct3),
        .lsu_addr_o    (lsu_addr),
        .lsu_st_data_o (lsu_st_data),
        .lsu_ld_data_i (lsu_ld_data)
    );

    // LSU model: word memory with byte/half extraction on loads.
    logic [31:0] mem [0:8191];
    int cyc = 0;
    int wren_cnt = 0;
    int wren_cyc = -1;

    always @(posedge clk) cyc <= cyc + 1;

    assign ld_word  = mem[lsu_addr[14:2]];
    assign ld_shift = ld_word >> {lsu_addr[1:0], 3'b000};

    always_comb begin
        lsu_ld_data = ld_shift;
        case (lsu_funct3)
            F3Lb:    lsu_ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
            F3Lh:    lsu_ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
            F3Lbu:   lsu_ld_data = {24'h0, ld_shift[7:0]};
            F3Lhu:   lsu_ld_data = {16'h0, ld_shift[15:0]};
            default: lsu_ld_data = ld_word;
        endcase
    end

    always @(posedge clk) begin
        if (lsu_wren) begin
            wren_cnt <= wren_cnt + 1;
            wren_cyc <= cyc;
            case (lsu_funct3)
                F3Sb: mem[lsu_addr[14:2]][{lsu_addr[1:0], 3'b000} +: 8] <= lsu_st_data[7:0];
                F3Sh: mem[lsu_addr[14:2]][{lsu_addr[1], 4'b0000} +: 16] <= lsu_st_data[15:0];
                default: mem[lsu_addr[14:2]] <= lsu_st_data;
            endcase
        end
    end

    initial begin
        for (int i = 0; i < 8192; i++) mem[i] <= 32'h0;
        mem[32'h2000 >> 2] <= 32'h1111_1111;
        mem[32'h2010 >> 2] <= 32'h2222_2222;
        mem[32'h7800 >> 2] <= 32'h0000_00A5;
    end

    typedef struct {
        logic        m;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb_q[$];
    logic gnt_order[$];
    int   checks = 0;
    int   passed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    endtask

    task automatic drive(input bit m, input logic v, input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d);
        if (m) begin
            m1_if.req_valid = v; m1_if.req_we = we; m1_if.funct3 = f3;
            m1_if.addr = a; m1_if.wdata = d;
        end else begin
            m0_if.req_valid = v; m0_if.req_we = we; m0_if.funct3 = f3;
            m0_if.addr = a; m0_if.wdata = d;
        end
    endtask

    task automatic issue(input bit m, input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] exp_rdata, input logic exp_err, output int hs_cyc);
        bit   done = 0;
        int   tries = 0;
        logic rdy;
        exp_t e;
        hs_cyc = -1;
        @(negedge clk);
        drive(m, 1'b1, we, f3, a, d);
        while (!done && tries < 50) begin
            #1;
            rdy = m ? m1_if.req_ready : m0_if.req_ready;
            if (rdy) begin
                e.m = m; e.rdata = exp_rdata; e.err = exp_err;
                sb_q.push_back(e);
                gnt_order.push_back(m);
                hs_cyc = cyc;
                @(posedge clk);
                #1;
                drive(m, 1'b0, we, f3, a, d);
                done = 1;
            end else begin
                tries++;
                @(negedge clk);
            end
        end
        if (!done) begin
            checks++;
            $display("FAIL handshake_timeout m%0d: ready never seen, required within 50 cycles", m);
            drive(m, 1'b0, we, f3, a, d);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            checks++;
            $display("FAIL drain: %0d responses outstanding, required 0", sb_q.size());
            sb_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    // Monitor: every response pulse must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (m0_if.resp_valid || m1_if.resp_valid) begin
                if (m0_if.resp_valid && m1_if.resp_valid) begin
                    checks++;
                    $display("FAIL resp_onehot: both resp_valid high, required one");
                end else if (sb_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_resp: m1=%0d, required no response",
                             m1_if.resp_valid);
                end else begin
                    e = sb_q.pop_front();
                    check("resp_master", {31'h0, m1_if.resp_valid}, {31'h0, e.m});
                    check("resp_rdata", resp_rdata, e.rdata);
                    check("resp_err", {31'h0, resp_err}, {31'h0, e.err});
                end
            end
        end
    end

    initial begin
        int          h0, h1, base;
        logic [5:0]  pattern;
        logic [3:0]  exp_order;
        logic        rdy;
        exp_t        e;

        drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        repeat (3) @(negedge clk);

        check("rst_m0_ready", {31'h0, m0_if.req_ready}, 32'h0);
        check("rst_resp_valid", {30'h0, m1_if.resp_valid, m0_if.resp_valid}, 32'h0);
        check("rst_wren", {31'h0, lsu_wren}, 32'h0);
        check("rst_lsu_addr", lsu_addr, 32'h0);
        check("rst_lsu_st_data", lsu_st_data, 32'h0);
        check("rst_lsu_funct3", {29'h0, lsu_funct3}, 32'h0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_resp_err", {31'h0, resp_err}, 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Contention straight after reset: m0 first, m1 accepted in m0's RESP cycle.
        fork
            issue(1'b0, 1'b0, F3Lw, 32'h2000, 32'h0, 32'h1111_1111, 1'b0, h0);
            issue(1'b1, 1'b0, F3Lw, 32'h2010, 32'h0, 32'h2222_2222, 1'b0, h1);
        join
        check("contend_m1_after_m0", h1 - h0, 32'd2);
        drain();

        // Store then load back; write strobe exactly one cycle, one cycle after handshake.
        base = wren_cnt;
        issue(1'b0, 1'b1, F3Sw, 32'h2004, 32'hDEAD_BEEF, 32'h0, 1'b0, h0);
        drain();
        check("sw_wren_count", wren_cnt - base, 32'd1);
        check("sw_wren_cycle", wren_cyc, h0 + 1);
        issue(1'b0, 1'b0, F3Lw, 32'h2004, 32'h0, 32'hDEAD_BEEF, 1'b0, h0);
        drain();

        // Illegal accesses never reach the LSU.
        base = wren_cnt;
        issue(1'b1, 1'b0, F3Lh, 32'h2001, 32'h0, 32'h0, 1'b1, h0);
        issue(1'b0, 1'b1, 3'b011, 32'h2000, 32'hFFFF_FFFF, 32'h0, 1'b1, h0);
        issue(1'b0, 1'b1, F3Sw, 32'h2002, 32'hFFFF_FFFF, 32'h0, 1'b1, h0);
        drain();
        check("illegal_no_wren", wren_cnt - base, 32'd0);

        // Back-to-back loads with valid held: accept every other cycle.
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, F3Lw, 32'h2004, 32'h0);
        pattern = '0;
        for (int i = 0; i < 6; i++) begin
            #1;
            rdy = m0_if.req_ready;
            pattern = {pattern[4:0], rdy};
            if (rdy) begin
                e.m = 1'b0; e.rdata = 32'hDEAD_BEEF; e.err = 1'b0;
                sb_q.push_back(e);
            end
            if (i < 5) @(negedge clk);
        end
        drive(1'b0, 1'b0, 1'b0, F3Lw, 32'h2004, 32'h0);
        check("b2b_ready_pattern", {26'h0, pattern}, 32'b101010);
        drain();

        // Async reset during ISSUE of a store aborts it with no response.
        base = wren_cnt;
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, F3Sw, 32'h2008, 32'h1234_5678);
        #1;
        check("rst_issue_ready", {31'h0, m0_if.req_ready}, 32'h1);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 1'b1, F3Sw, 32'h2008, 32'h1234_5678);
        check("issue_wren_high", {31'h0, lsu_wren}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("rst_wren_abort", {31'h0, lsu_wren}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_no_store", wren_cnt - base, 32'd0);
        issue(1'b0, 1'b0, F3Lw, 32'h2008, 32'h0, 32'h0, 1'b0, h0);
        drain();

        // Byte/half loads through m1 and m0.
        issue(1'b1, 1'b0, F3Lbu, 32'h7800, 32'h0, 32'h0000_00A5, 1'b0, h0);
        issue(1'b1, 1'b0, F3Lb, 32'h7800, 32'h0, 32'hFFFF_FFA5, 1'b0, h0);
        issue(1'b0, 1'b0, F3Lh, 32'h2006, 32'h0, 32'hFFFF_DEAD, 1'b0, h0);
        drain();

        // Four contended requests; last handshake was m0 so round-robin favours m1 first.
        gnt_order.delete();
        fork
            begin
                issue(1'b0, 1'b0, F3Lw, 32'h2000, 32'h0, 32'h1111_1111, 1'b0, h0);
                issue(1'b0, 1'b0, F3Lw, 32'h2000, 32'h0, 32'h1111_1111, 1'b0, h0);
            end
            begin
                issue(1'b1, 1'b0, F3Lw, 32'h2010, 32'h0, 32'h2222_2222, 1'b0, h1);
                issue(1'b1, 1'b0, F3Lw, 32'h2010, 32'h0, 32'h2222_2222, 1'b0, h1);
            end
        join
        drain();
`ifdef LSU_ARB_RR_EN
        exp_order = 4'b1010;
`else
        exp_order = 4'b0011;
`endif
        check("contend4_count", gnt_order.size(), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < gnt_order.size()) begin
                check("contend4_grant", {31'h0, gnt_order[i]}, {31'h0, exp_order[3-i]});
            end
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running, required completion");
        $fatal(1, "timeout");
    end
endmodule
